// File: rtl/gpio_debounce_pkg.sv
// Shared constants and types for the GPIO input debouncer.
// Pure definitions: no latency, no flow control.
package gpio_debounce_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int DEFAULT_CNT_W           = 20;

   typedef enum logic [1:0] {
      EDGE_NONE,
      EDGE_RISE,
      EDGE_FALL
   } edge_e;

   // Stability window must be at least one cycle and reachable by the counter.
   function automatic logic cycles_legal(input int cycles, input int cnt_w);
      return (cycles >= 1) && (longint'(cycles) <= ((longint'(1) << cnt_w) - 1));
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One input bit: 2-flop synchroniser, stability counter, debounced level and registered edge.
// Latency: 2 + DEBOUNCE_CYCLES cycles from raw edge to level; no backpressure (level input).
module debounce_chan
   import gpio_debounce_pkg::*;
#(
   parameter int   CNT_W           = DEFAULT_CNT_W,
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic  clk,
   input  logic  rstn,
   input  logic  i_raw,
   output logic  o_level,
   output edge_e o_edge,
   output edge_e o_edge_nxt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             level_d;
   edge_e            edge_q;
   edge_e            edge_d;

   // Synchroniser pair is kept free of any logic between the two flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= RESET_VAL;
         sync2_q <= RESET_VAL;
      end else begin
         sync1_q <= i_raw;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      edge_d  = EDGE_NONE;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         level_d = sync2_q;
         edge_d  = sync2_q ? EDGE_RISE : EDGE_FALL;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q   <= '0;
         level_q <= RESET_VAL;
         edge_q  <= EDGE_NONE;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         edge_q  <= edge_d;
      end
   end

   assign o_level    = level_q;
   assign o_edge     = edge_q;
   assign o_edge_nxt = edge_d;

endmodule

// File: rtl/gpio_debounce.sv
// WIDTH-channel GPIO debouncer with edge pulses, W1C sticky press flags and optional IRQ (GPIO_DEBOUNCE_IRQ_EN).
// Latency: 2 + DEBOUNCE_CYCLES cycles raw->level, IRQ one cycle after flags; no backpressure.
module gpio_debounce
   import gpio_debounce_pkg::*;
#(
   parameter int               WIDTH           = 5,
   parameter int               CNT_W           = DEFAULT_CNT_W,
   parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] i_raw,
   input  logic [WIDTH-1:0] i_clr,
`ifdef GPIO_DEBOUNCE_IRQ_EN
   input  logic [WIDTH-1:0] i_irq_mask,
`endif
   output logic [WIDTH-1:0] o_level,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic [WIDTH-1:0] o_pressed,
   output logic             o_irq
);

   if (!cycles_legal(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cycles
      $fatal(1, "gpio_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
   end

   edge_e            edge_q   [WIDTH];
   edge_e            edge_nxt [WIDTH];
   logic [WIDTH-1:0] rise_nxt;
   logic [WIDTH-1:0] pressed_q;
   logic [WIDTH-1:0] pressed_d;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      debounce_chan #(
         .CNT_W           (CNT_W),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (RESET_VAL[gi])
      ) u_chan (
         .clk        (clk),
         .rstn       (rstn),
         .i_raw      (i_raw[gi]),
         .o_level    (o_level[gi]),
         .o_edge     (edge_q[gi]),
         .o_edge_nxt (edge_nxt[gi])
      );

      assign o_rise[gi]   = (edge_q[gi] == EDGE_RISE);
      assign o_fall[gi]   = (edge_q[gi] == EDGE_FALL);
      assign rise_nxt[gi] = (edge_nxt[gi] == EDGE_RISE);
   end

   // The flag sets on the same edge the level rises, so a coincident clear loses.
   always_comb begin
      pressed_d = (pressed_q & ~i_clr) | rise_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pressed_q <= '0;
      end else begin
         pressed_q <= pressed_d;
      end
   end

   assign o_pressed = pressed_q;

`ifdef GPIO_DEBOUNCE_IRQ_EN
   logic irq_q;
   logic irq_d;

   always_comb begin
      irq_d = |(pressed_q & i_irq_mask);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign o_irq = irq_q;
`else
   assign o_irq = 1'b0;
`endif

endmodule
